// File: rtl/inport_debounce.sv
// Registered pin inputs, two-stage sampling, per-bit debounce and sticky rise/fall events.
// Optional INPORT_IRQ_EN adds a registered level interrupt from masked rise|fall bits.

module inport_debounce_bit #(
    parameter int   DEB_W      = 16,
    parameter int   DEB_CYCLES = 12000,
    parameter logic INIT_BIT   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic rd_o,
    output logic rise_o,
    output logic fall_o
);
    localparam logic [DEB_W-1:0] LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] ONE  = DEB_W'(1);

    logic             pin_q;
    logic             sync_q;
    logic             rd_q, rd_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             commit;

    // Stands in for the SB_IO input register; it has no reset and is packed into the IO cell.
    always_ff @(posedge clk) begin
        pin_q <= pin_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 1'b0;
            rd_q   <= INIT_BIT;
            cnt_q  <= '0;
        end else begin
            sync_q <= pin_q;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end

    // Any sample that agrees with rd throws away the accumulated run.
    always_comb begin
        cnt_d  = cnt_q;
        rd_d   = rd_q;
        commit = 1'b0;
        if (sync_q == rd_q) begin
            cnt_d = '0;
        end else if (cnt_q >= LAST) begin
            cnt_d  = '0;
            rd_d   = sync_q;
            commit = 1'b1;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    assign rd_o   = rd_q;
    assign rise_o = commit & sync_q;
    assign fall_o = commit & ~sync_q;
endmodule

module inport_debounce #(
    parameter int               WIDTH      = 8,
    parameter int               DEB_W      = 16,
    parameter int               DEB_CYCLES = 12000,
    parameter logic [WIDTH-1:0] INIT       = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] rd,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    input  logic             clr,
    input  logic [WIDTH-1:0] clr_mask,
    input  logic [WIDTH-1:0] irq_mask,
    output logic             irq
);
    logic [WIDTH-1:0] new_rise, new_fall;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] clr_bits;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        inport_debounce_bit #(
            .DEB_W      (DEB_W),
            .DEB_CYCLES (DEB_CYCLES),
            .INIT_BIT   (INIT[i])
        ) u_bit (
            .clk    (clk),
            .reset  (reset),
            .pin_i  (pins[i]),
            .rd_o   (rd[i]),
            .rise_o (new_rise[i]),
            .fall_o (new_fall[i])
        );
    end

    // A new event on a bit wins over a clear of that bit in the same cycle.
    always_comb begin
        clr_bits = clr ? clr_mask : '0;
        rise_d   = (rise_q & ~clr_bits) | new_rise;
        fall_d   = (fall_q & ~clr_bits) | new_fall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

`ifdef INPORT_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |((rise_q | fall_q) & irq_mask);
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_mask;

    assign unused_irq_mask = ^irq_mask;
    assign irq             = 1'b0;
`endif
endmodule

// File: tb/tb_inport_debounce.sv
// Bench for inport_debounce: vector table, hand sequences for reset/irq, random run vs. a windowed model.
module tb_inport_debounce;
    localparam int W   = 8;
    localparam int DEB = 4;
    localparam logic [W-1:0] INIT = 8'hFF;
`ifdef INPORT_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] pins;
    logic [W-1:0] rd, rise, fall;
    logic         clr;
    logic [W-1:0] clr_mask;
    logic [W-1:0] irq_mask;
    logic         irq;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    inport_debounce #(
        .WIDTH      (W),
        .DEB_W      (16),
        .DEB_CYCLES (DEB),
        .INIT       (INIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pins     (pins),
        .rd       (rd),
        .rise     (rise),
        .fall     (fall),
        .clr      (clr),
        .clr_mask (clr_mask),
        .irq_mask (irq_mask),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a bit commits once the last DEB samples since its last commit all differ from rd.
    logic [W-1:0] m_pinq, m_sync, m_rd, m_rise, m_fall;
    logic         m_irq;
    bit           hist [W][$];

    always @(posedge clk) begin
        logic [W-1:0] nr, nf, rdn, cm;
        int k;
        if (reset) begin
            m_pinq = pins;
            m_sync = '0;
            m_rd   = INIT;
            m_rise = '0;
            m_fall = '0;
            m_irq  = 1'b0;
            for (int i = 0; i < W; i++) hist[i].delete();
        end else begin
            nr  = '0;
            nf  = '0;
            rdn = m_rd;
            for (int i = 0; i < W; i++) begin
                hist[i].push_back(m_sync[i]);
                if (hist[i].size() > DEB) void'(hist[i].pop_front());
                k = 0;
                for (int j = 0; j < hist[i].size(); j++)
                    if (hist[i][j] != m_rd[i]) k++;
                if (k == DEB) begin
                    rdn[i] = ~m_rd[i];
                    if (m_rd[i]) nf[i] = 1'b1;
                    else         nr[i] = 1'b1;
                    hist[i].delete();
                end
            end
            m_irq  = IRQ_ON & (|((m_rise | m_fall) & irq_mask));
            cm     = clr ? clr_mask : '0;
            m_rise = (m_rise & ~cm) | nr;
            m_fall = (m_fall & ~cm) | nf;
            m_rd   = rdn;
            m_sync = m_pinq;
            m_pinq = pins;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_rd", rd, m_rd);
            chk("model_rise", rise, m_rise);
            chk("model_fall", fall, m_fall);
            chk("model_irq", {7'b0, irq}, {7'b0, m_irq});
        end
    end

    typedef struct {
        logic [W-1:0] pins;
        logic         clr;
        logic [W-1:0] cmask;
        int           n;
        logic [W-1:0] rd;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // idle, exact pin->rd latency, bounce rejection, set-beats-clear, clear variants, multi-bit rise
        tbl.push_back('{8'hFF, 1'b0, 8'h00, 20, 8'hFF, 8'h00, 8'h00});
        tbl.push_back('{8'hFE, 1'b0, 8'h00, 5,  8'hFF, 8'h00, 8'h00});
        tbl.push_back('{8'hFE, 1'b0, 8'h00, 1,  8'hFE, 8'h00, 8'h01});
        for (int r = 0; r < 5; r++) begin
            tbl.push_back('{8'hFC, 1'b0, 8'h00, 3, 8'hFE, 8'h00, 8'h01});
            tbl.push_back('{8'hFE, 1'b0, 8'h00, 3, 8'hFE, 8'h00, 8'h01});
        end
        tbl.push_back('{8'hFA, 1'b0, 8'h00, 5,  8'hFE, 8'h00, 8'h01});
        tbl.push_back('{8'hFA, 1'b1, 8'h01, 1,  8'hFA, 8'h00, 8'h04});
        tbl.push_back('{8'hFA, 1'b0, 8'h00, 2,  8'hFA, 8'h00, 8'h04});
        tbl.push_back('{8'hFA, 1'b1, 8'h00, 1,  8'hFA, 8'h00, 8'h04});
        tbl.push_back('{8'hFA, 1'b1, 8'hFF, 1,  8'hFA, 8'h00, 8'h00});
        tbl.push_back('{8'hFF, 1'b0, 8'h00, 6,  8'hFF, 8'h05, 8'h00});
        tbl.push_back('{8'hFF, 1'b1, 8'h01, 1,  8'hFF, 8'h04, 8'h00});

        reset    = 1'b1;
        pins     = 8'hFF;
        clr      = 1'b0;
        clr_mask = '0;
        irq_mask = '0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_rd", rd, INIT);
        chk("reset_rise", rise, 8'h00);
        chk("reset_fall", fall, 8'h00);
        chk("reset_irq", {7'b0, irq}, 8'h00);
        reset = 1'b0;

        for (int v = 0; v < tbl.size(); v++) begin
            pins     = tbl[v].pins;
            clr      = tbl[v].clr;
            clr_mask = tbl[v].cmask;
            repeat (tbl[v].n) @(negedge clk);
            chk($sformatf("vec%0d_rd", v), rd, tbl[v].rd);
            chk($sformatf("vec%0d_rise", v), rise, tbl[v].rise);
            chk($sformatf("vec%0d_fall", v), fall, tbl[v].fall);
        end
        clr      = 1'b0;
        clr_mask = '0;

        // reset in the middle of a pending pins[3] change
        pins = 8'hF7;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid_rd", rd, 8'hFF);
        chk("rst_mid_rise", rise, 8'h00);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_post_rd_hold", rd, 8'hFF);
        chk("rst_post_fall_hold", fall, 8'h00);
        @(negedge clk);
        chk("rst_post_rd", rd, 8'hF7);
        chk("rst_post_fall", fall, 8'h08);

        // masked interrupt from pins[4]
        irq_mask = 8'h10;
        pins     = 8'hE7;
        repeat (6) @(negedge clk);
        chk("irq_fall_set", fall, 8'h18);
        chk("irq_lag", {7'b0, irq}, 8'h00);
        @(negedge clk);
        chk("irq_on", {7'b0, irq}, {7'b0, IRQ_ON});
        clr      = 1'b1;
        clr_mask = 8'h10;
        @(negedge clk);
        clr = 1'b0;
        chk("irq_clr_fall", fall, 8'h08);
        chk("irq_clr_lag", {7'b0, irq}, {7'b0, IRQ_ON});
        @(negedge clk);
        chk("irq_off", {7'b0, irq}, 8'h00);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) pins = pins ^ (8'($urandom) & 8'($urandom));
            clr      = ($urandom_range(0, 9) == 0);
            clr_mask = 8'($urandom);
            if ($urandom_range(0, 49) == 0) irq_mask = 8'($urandom);
            reset = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        clr   = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
